// File: rtl/divide_operator_seq.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// One quotient bit per cycle behind a valid/ready handshake; divide-by-zero short-circuits to DONE.
module divide_operator_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] Z,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           div_zero
);

  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [2*N-1:0]  dq_q;
  logic [2*N-1:0]  dq_d;
  logic [N-1:0]    div_q;
  logic [N:0]      rem_q;
  logic [N:0]      rem_d;
  logic [N:0]      rem_sh;
  logic [CW-1:0]   cnt_q;

  // One restoring step: dividend bits leave dq at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem_q[N-1:0], dq_q[2*N-1]};
    rem_d  = rem_sh;
    dq_d   = {dq_q[2*N-2:0], 1'b0};
    if (rem_sh >= {1'b0, div_q}) begin
      rem_d = rem_sh - {1'b0, div_q};
      dq_d  = {dq_q[2*N-2:0], 1'b1};
    end else begin
      rem_d = rem_sh;
      dq_d  = {dq_q[2*N-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= {(2*N){1'b0}};
      R         <= {N{1'b0}};
      div_zero  <= 1'b0;
      dq_q      <= {(2*N){1'b0}};
      div_q     <= {N{1'b0}};
      rem_q     <= {(N+1){1'b0}};
      cnt_q     <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dq_q     <= Z;
            div_q    <= B;
            rem_q    <= {(N+1){1'b0}};
            cnt_q    <= {CW{1'b0}};
            in_ready <= 1'b0;
            if (B != {N{1'b0}}) begin
              state_q <= RUN;
            end else begin
              state_q   <= DONE;
              Q         <= {(2*N){1'b1}};
              R         <= {N{1'b0}};
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          dq_q  <= dq_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          // The remainder is always below the divisor after a step, so its top bit is zero.
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            Q         <= dq_d;
            R         <= rem_d[N-1:0];
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
